// File: rtl/sram_mem_responder.sv
// MEM-stage data-memory responder: serves one 32-bit read/write as two 16-bit async SRAM accesses.
// Latency: request in cycle 0 -> ready=1 in cycle 2*WAIT_CYCLES+1 for one cycle, then one IDLE cycle.
// Backpressure: ready is held low while a request is pending or in flight, which freezes the pipeline.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wr_en, rd_en             request strobes from MEM stage, held until ready (wr_en wins if both)
//   address, write_data      byte address and store data, latched when the request is accepted
//   read_data, ready         load data and access-complete / idle indication
//   sram_addr                halfword address {word_addr[16:0], half}
//   sram_dq_o/_i/_oe         SRAM data out, data in, output enable
//   sram_we_n                SRAM write strobe, active low
module sram_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_o,
    input  logic [15:0] sram_dq_i,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_wr_q, is_wr_d;
    logic [16:0] waddr_q, waddr_d;
    logic [15:0] wdata_hi_q, wdata_hi_d;
    logic [31:0] read_data_q, read_data_d;
    logic [17:0] sram_addr_q, sram_addr_d;
    logic [15:0] sram_dq_o_q, sram_dq_o_d;
    logic        sram_dq_oe_q, sram_dq_oe_d;
    logic        sram_we_n_q, sram_we_n_d;

    // Offset subtraction truncates to 32 bits, so addresses below the base simply wrap.
    logic [31:0] addr_off;
    logic        unused_addr_bits;
    logic        req;
    logic        last;

    assign addr_off         = address - BASE_ADDR;
    assign unused_addr_bits = ^{addr_off[31:19], addr_off[1:0]};
    assign req              = rd_en | wr_en;
    assign last             = (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_wr_d      = is_wr_q;
        waddr_d      = waddr_q;
        wdata_hi_d   = wdata_hi_q;
        read_data_d  = read_data_q;
        sram_addr_d  = sram_addr_q;
        sram_dq_o_d  = sram_dq_o_q;
        sram_dq_oe_d = sram_dq_oe_q;
        sram_we_n_d  = sram_we_n_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    // Latch the whole request here; later input changes are ignored.
                    state_d      = LOW;
                    cnt_d        = 4'd0;
                    is_wr_d      = wr_en;
                    waddr_d      = addr_off[18:2];
                    wdata_hi_d   = write_data[31:16];
                    sram_addr_d  = {addr_off[18:2], 1'b0};
                    sram_dq_o_d  = write_data[15:0];
                    sram_dq_oe_d = wr_en;
                    sram_we_n_d  = ~wr_en;
                end
            end
            LOW: begin
                if (last) begin
                    state_d     = HIGH;
                    cnt_d       = 4'd0;
                    sram_addr_d = {waddr_q, 1'b1};
                    sram_dq_o_d = wdata_hi_q;
                    if (!is_wr_q) begin
                        read_data_d[15:0] = sram_dq_i;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HIGH: begin
                if (last) begin
                    state_d      = DONE;
                    cnt_d        = 4'd0;
                    sram_dq_oe_d = 1'b0;
                    sram_we_n_d  = 1'b1;
                    if (!is_wr_q) begin
                        read_data_d[31:16] = sram_dq_i;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                // Always pass through IDLE so a held request is re-sampled there.
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            is_wr_q      <= 1'b0;
            waddr_q      <= 17'd0;
            wdata_hi_q   <= 16'd0;
            read_data_q  <= 32'd0;
            sram_addr_q  <= 18'd0;
            sram_dq_o_q  <= 16'd0;
            sram_dq_oe_q <= 1'b0;
            sram_we_n_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_wr_q      <= is_wr_d;
            waddr_q      <= waddr_d;
            wdata_hi_q   <= wdata_hi_d;
            read_data_q  <= read_data_d;
            sram_addr_q  <= sram_addr_d;
            sram_dq_o_q  <= sram_dq_o_d;
            sram_dq_oe_q <= sram_dq_oe_d;
            sram_we_n_q  <= sram_we_n_d;
        end
    end

    // A request seen in IDLE pulls ready low in the same cycle.
    assign ready      = (state_q == DONE) | ((state_q == IDLE) & ~req);
    assign read_data  = read_data_q;
    assign sram_addr  = sram_addr_q;
    assign sram_dq_o  = sram_dq_o_q;
    assign sram_dq_oe = sram_dq_oe_q;
    assign sram_we_n  = sram_we_n_q;

endmodule

// File: tb/tb_sram_mem_responder.sv
// Bench for sram_mem_responder: table of directed transactions plus hand-written corner sequences.
// Latency: checks every cycle of each access against hand-computed values.
// Backpressure: requests are held until ready, as the MEM stage does.
module tb_sram_mem_responder;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic [15:0] sram_dq_i;
    logic        sram_dq_oe;
    logic        sram_we_n;

    int total;
    int bad;

    sram_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM model, low 8 address bits only.
    logic [15:0] mem [0:255];
    assign sram_dq_i = mem[sram_addr[7:0]];
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq_o;
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chg;        // move address to 2000 in cycle 3
        logic [17:0] exp_lo;     // expected LOW-phase sram_addr
        logic        exp_write;
        logic [31:0] exp_rd;     // expected read_data at completion
    } vec_t;

    vec_t vec [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in an IDLE cycle at posedge+1; returns in the following IDLE cycle.
    task automatic run_txn(input vec_t v);
        address    = v.addr;
        write_data = v.wdata;
        rd_en      = v.rd;
        wr_en      = v.wr;
        #1;
        chk("ready_c0", {31'd0, ready}, 32'd0);
        for (int c = 1; c <= 11; c++) begin
            step();
            if (c == 3 && v.chg) address = 32'd2000;
            if (c <= 10) begin
                chk("ready_busy", {31'd0, ready}, 32'd0);
                chk("sram_addr", {14'd0, sram_addr}, {14'd0, (c <= 5) ? v.exp_lo : (v.exp_lo | 18'd1)});
                chk("we_n", {31'd0, sram_we_n}, {31'd0, ~v.exp_write});
                chk("dq_oe", {31'd0, sram_dq_oe}, {31'd0, v.exp_write});
                if (v.exp_write)
                    chk("dq_o", {16'd0, sram_dq_o}, {16'd0, (c <= 5) ? v.wdata[15:0] : v.wdata[31:16]});
            end else begin
                chk("ready_done", {31'd0, ready}, 32'd1);
                chk("read_data", read_data, v.exp_rd);
                chk("we_n_done", {31'd0, sram_we_n}, 32'd1);
                chk("dq_oe_done", {31'd0, sram_dq_oe}, 32'd0);
            end
        end
        rd_en = 1'b0;
        wr_en = 1'b0;
        step();
        chk("ready_idle", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;

        //          rd    wr    addr    wdata          chg   exp_lo      wr    exp_rd
        vec[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, 18'h00002, 1'b1, 32'h00000000};
        vec[1] = '{1'b1, 1'b0, 32'd1028, 32'h00000000, 1'b0, 18'h00002, 1'b0, 32'hDEADBEEF};
        vec[2] = '{1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b1, 18'h00000, 1'b1, 32'hDEADBEEF};
        vec[3] = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 1'b0, 18'h00000, 1'b0, 32'h12345678};
        vec[4] = '{1'b0, 1'b1, 32'd1020, 32'hA5A55A5A, 1'b0, 18'h3FFFE, 1'b1, 32'h12345678};
        vec[5] = '{1'b1, 1'b0, 32'd1020, 32'h00000000, 1'b0, 18'h3FFFE, 1'b0, 32'hA5A55A5A};
        vec[6] = '{1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 1'b0, 18'h00004, 1'b1, 32'hA5A55A5A};
        vec[7] = '{1'b1, 1'b0, 32'd1032, 32'h00000000, 1'b0, 18'h00004, 1'b0, 32'hCAFEF00D};

        // Reset state
        rst        = 1'b1;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        address    = 32'd0;
        write_data = 32'd0;
        step();
        step();
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
        chk("rst_dq_o", {16'd0, sram_dq_o}, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_txn(vec[i]);

        // Back-to-back reads with the request held; address moves to 1032 once the first completes.
        address = 32'd1028;
        rd_en   = 1'b1;
        #1;
        for (int c = 0; c <= 23; c++) begin
            if (c > 0) step();
            chk("b2b_ready", {31'd0, ready}, {31'd0, (c == 11) || (c == 23)});
            if (c == 11) begin
                chk("b2b_rd0", read_data, 32'hDEADBEEF);
                address = 32'd1032;
            end
            if (c == 23) chk("b2b_rd1", read_data, 32'hCAFEF00D);
        end
        rd_en = 1'b0;
        step();
        chk("b2b_idle", {31'd0, ready}, 32'd1);

        // Reset in cycle 7 of a write aborts it and clears read_data.
        address    = 32'd1036;
        write_data = 32'h11112222;
        wr_en      = 1'b1;
        for (int c = 1; c <= 7; c++) step();
        chk("abort_we_n_c7", {31'd0, sram_we_n}, 32'd0);
        rst   = 1'b1;
        wr_en = 1'b0;
        step();
        chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("abort_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("abort_read_data", read_data, 32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd1);
        rst = 1'b0;
        step();
        run_txn('{1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, 18'h00002, 1'b0, 32'hDEADBEEF});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
